// File: rtl/tsc_mem_pkg.sv
// Shared types and constants for the TSC memory responder: FSM states,
// operation encoding and the boot program image reloaded on every reset.
package tsc_mem_pkg;

  localparam int DEFAULT_WORD_SIZE   = 16;
  localparam int DEFAULT_MEMORY_SIZE = 32;
  localparam int unsigned BOOT_LEN   = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
    16'h6000, 16'h6101, 16'h6202, 16'h6303, 16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c,
    16'h4204, 16'h47fc, 16'hf81c, 16'hfc1c, 16'hf6c0, 16'hf180, 16'hf81c, 16'hfc1c,
    16'h9015, 16'hf01c, 16'hf180, 16'hf180, 16'hf180, 16'h6000, 16'h4000, 16'hfd80,
    16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c
  };

  // Words past the end of the image reload as zero.
  function automatic logic [15:0] boot_word(input int unsigned idx);
    logic [15:0] w;
    w = '0;
    if (idx < BOOT_LEN) w = BOOT_IMAGE[idx[4:0]];
    return w;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter pacing the access latency; done flags the last wait cycle.
module mem_latency_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/tsc_memory_responder.sv
// Request/acknowledge memory responder with fixed access latency and a boot
// image that is reloaded on every reset.
//  state | meaning
//  IDLE  | waiting for readM/writeM; request latched on acceptance
//  WAIT  | latency counting down, request inputs ignored
//  RESP  | one-cycle inputReady (read) or ackOutput (write) pulse
module tsc_memory_responder
  import tsc_mem_pkg::*;
#(
  parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
  parameter int MEMORY_SIZE = DEFAULT_MEMORY_SIZE,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset_cpu,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy
);

  localparam int AW    = $clog2(MEMORY_SIZE);
  localparam int CNT_W = 4;

  state_e state, state_nx;

  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

  logic [AW-1:0]        addr_q;
  logic [WORD_SIZE-1:0] data_q;
  op_e                  op_q;
  logic                 in_range_q;
  logic [WORD_SIZE-1:0] data_hold;
  logic [WORD_SIZE-1:0] rdata;

  logic accept;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_done;
  logic resp_read;
  logic resp_write;

  mem_latency_counter #(
    .WIDTH(CNT_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset_cpu),
    .load      (cnt_load),
    .load_value(CNT_W'(LATENCY - 1)),
    .dec       (cnt_dec),
    .done      (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (readM || writeM) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Read wins when both requests are high; the range check is captured here so
  // out-of-range addresses never reach the array index.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= address[AW-1:0];
      data_q     <= data_in;
      op_q       <= readM ? OP_READ : OP_WRITE;
      in_range_q <= (address < WORD_SIZE'(MEMORY_SIZE));
    end
  end

  assign resp_read  = (state == RESP) && (op_q == OP_READ);
  assign resp_write = (state == RESP) && (op_q == OP_WRITE);

  assign rdata = in_range_q ? mem[addr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      for (int i = 0; i < MEMORY_SIZE; i++) begin
        mem[i] <= WORD_SIZE'(boot_word(i));
      end
    end else if (resp_write && in_range_q) begin
      mem[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      data_hold <= '0;
    end else if (resp_read) begin
      data_hold <= rdata;
    end
  end

  assign data_out   = resp_read ? rdata : data_hold;
  assign inputReady = resp_read;
  assign ackOutput  = resp_write;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_tsc_memory_responder.sv
// Directed bench for tsc_memory_responder: LATENCY=2 instance for the main
// sequence plus a LATENCY=1 instance for back-to-back held requests.
module tb_tsc_memory_responder;

  logic        clk;
  logic        reset_cpu;
  logic        readM, writeM;
  logic [15:0] address, data_in;
  logic [15:0] data_out;
  logic        inputReady, ackOutput, busy;

  logic        readM1, writeM1;
  logic [15:0] address1, data_in1;
  logic [15:0] data_out1;
  logic        inputReady1, ackOutput1, busy1;

  int tests;
  int fails;

  logic [15:0] img [32] = '{
    16'h6000, 16'h6101, 16'h6202, 16'h6303, 16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c,
    16'h4204, 16'h47fc, 16'hf81c, 16'hfc1c, 16'hf6c0, 16'hf180, 16'hf81c, 16'hfc1c,
    16'h9015, 16'hf01c, 16'hf180, 16'hf180, 16'hf180, 16'h6000, 16'h4000, 16'hfd80,
    16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  tsc_memory_responder #(.WORD_SIZE(16), .MEMORY_SIZE(32), .LATENCY(2)) dut (
    .clk(clk), .reset_cpu(reset_cpu), .readM(readM), .writeM(writeM),
    .address(address), .data_in(data_in), .data_out(data_out),
    .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy)
  );

  tsc_memory_responder #(.WORD_SIZE(16), .MEMORY_SIZE(32), .LATENCY(1)) dut1 (
    .clk(clk), .reset_cpu(reset_cpu), .readM(readM1), .writeM(writeM1),
    .address(address1), .data_in(data_in1), .data_out(data_out1),
    .inputReady(inputReady1), .ackOutput(ackOutput1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    readM = 1'b0; writeM = 1'b0; readM1 = 1'b0; writeM1 = 1'b0;
    reset_cpu = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_cpu = 1'b0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic transact(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] dout,
                          output int lat, output int n_ir, output int n_ack,
                          output logic busy_mid);
    lat = -1; n_ir = 0; n_ack = 0; dout = '0; busy_mid = 1'b0;
    readM = rd; writeM = wr; address = a; data_in = d;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) busy_mid = busy;
      if (inputReady) n_ir++;
      if (ackOutput) n_ack++;
      if ((inputReady || ackOutput) && lat < 0) begin
        lat  = k;
        dout = data_out;
      end
      @(posedge clk);
      #1;
      if (lat > 0) begin
        readM = 1'b0; writeM = 1'b0;
      end
      if (lat > 0 && k >= lat + 2) break;
    end
    readM = 1'b0; writeM = 1'b0;
  endtask

  logic [15:0] dout;
  int          lat, n_ir, n_ack;
  logic        bm;
  int          pulses;

  initial begin
    tests = 0; fails = 0;
    readM = 0; writeM = 0; address = 0; data_in = 0;
    readM1 = 0; writeM1 = 0; address1 = 0; data_in1 = 0;
    reset_cpu = 1'b1;

    do_reset();
    @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_inputReady", 32'(inputReady), 32'h0);
    check("rst_ackOutput", 32'(ackOutput), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;

    transact(1'b1, 1'b0, 16'd0, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd0_latency", 32'(lat), 32'd2);
    check("rd0_data", 32'(dout), 32'h6000);
    check("rd0_pulses", 32'(n_ir), 32'd1);
    check("rd0_busy_wait", 32'(bm), 32'h1);

    transact(1'b1, 1'b0, 16'd16, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd16_data", 32'(dout), 32'h9015);

    transact(1'b0, 1'b1, 16'd5, 16'hABCD, dout, lat, n_ir, n_ack, bm);
    check("wr5_latency", 32'(lat), 32'd2);
    check("wr5_ack_pulses", 32'(n_ack), 32'd1);
    check("wr5_no_ir", 32'(n_ir), 32'd0);
    @(negedge clk);
    check("data_out_hold", 32'(data_out), 32'h9015);
    check("idle_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;

    transact(1'b1, 1'b0, 16'd5, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd5_after_wr", 32'(dout), 32'hABCD);

    do_reset();
    transact(1'b1, 1'b0, 16'd30, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd30_data", 32'(dout), 32'h0000);
    transact(1'b1, 1'b0, 16'd5, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd5_reloaded", 32'(dout), 32'hf41c);

    transact(1'b1, 1'b0, 16'd40, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd40_ir", 32'(n_ir), 32'd1);
    check("rd40_data", 32'(dout), 32'h0000);
    transact(1'b0, 1'b1, 16'd40, 16'h1234, dout, lat, n_ir, n_ack, bm);
    check("wr40_ack", 32'(n_ack), 32'd1);
    for (int i = 0; i < 32; i++) begin
      transact(1'b1, 1'b0, 16'(i), 16'h0, dout, lat, n_ir, n_ack, bm);
      check($sformatf("scan_%0d", i), 32'(dout), 32'(img[i]));
    end

    transact(1'b1, 1'b1, 16'd3, 16'hFFFF, dout, lat, n_ir, n_ack, bm);
    check("both_ir", 32'(n_ir), 32'd1);
    check("both_data", 32'(dout), 32'h6303);
    check("both_no_ack", 32'(n_ack), 32'd0);
    transact(1'b1, 1'b0, 16'd3, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd3_unchanged", 32'(dout), 32'h6303);

    writeM = 1'b1; address = 16'd2; data_in = 16'h5555;
    @(posedge clk); #1;
    reset_cpu = 1'b1; writeM = 1'b0;
    pulses = 0;
    @(negedge clk);
    if (ackOutput || inputReady) pulses++;
    @(posedge clk); #1;
    reset_cpu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check("abort_busy", 32'(busy), 32'h0);
      if (ackOutput || inputReady) pulses++;
      @(posedge clk); #1;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    transact(1'b1, 1'b0, 16'd2, 16'h0, dout, lat, n_ir, n_ack, bm);
    check("rd2_after_abort", 32'(dout), 32'h6202);

    do_reset();
    readM1 = 1'b1; address1 = 16'd1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("lat1_ir_%0d", k), 32'(inputReady1), (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k % 2 == 0) check($sformatf("lat1_data_%0d", k), 32'(data_out1), 32'h6101);
      @(posedge clk); #1;
    end
    readM1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
